// File: rtl/hdmi_to_matrix_top.sv
// hdmi_to_matrix_top: test-pattern streamer for a chain of 16x8 SPI RGB matrices
// with 595 group select and optional TMDS activity detector (macro HDMI_DETECT_EN).
`default_nettype none

module hdmi_to_matrix_top #(
  parameter int SPI_DIV       = 2,
  parameter int SR_BITS       = 8,
  parameter int BYTES         = 48,
  parameter int GAP_CYCLES    = 16,
  parameter int DET_WINDOW    = 27000,
  parameter int DET_MIN_EDGES = 4,
  parameter int HB_BITS       = 24
) (
  input  logic       sys_clk_27MHz,
  input  logic       rst,
  input  logic [1:0] btn,
  input  logic       I_tmds_clk_p,
  input  logic       I_tmds_clk_n,
  input  logic [2:0] I_tmds_data_p,
  input  logic [2:0] I_tmds_data_n,
  output logic       spi_clk,
  output logic [7:0] spi_mosi,
  output logic       shift_clk,
  output logic       shift_ser,
  output logic       shift_stcp,
  output logic       shift_en,
  output logic [5:0] led
);

  localparam int GW        = (SR_BITS > 1) ? $clog2(SR_BITS) : 1;
  localparam int XFER_BITS = BYTES * 8;

  typedef enum logic [1:0] {S_SHIFT, S_LATCH, S_XFER, S_GAP} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_cnt;
  logic [15:0]     r_div;
  logic [GW-1:0]   r_g;
  logic [7:0]      r_f;
  logic            r_mode, r_pause;
  logic [1:0]      r_btn_meta, r_btn_sync;
  logic            w_shift_done, w_div_last, w_xfer_done, w_gap_done;
  logic [7:0]      w_base;
  logic [2:0]      w_bitsel;
  logic [7:0]      w_lane_bits;
  logic            w_hdmi_present;
  logic [HB_BITS-1:0] r_hb_cnt;
  logic            r_hb;
  logic            w_unused;

  always_comb begin
    w_next       = r_state;
    w_shift_done = (r_cnt == 16'(2 * SR_BITS - 1));
    w_div_last   = (r_div == 16'(2 * SPI_DIV - 1));
    w_xfer_done  = w_div_last && (r_cnt == 16'(XFER_BITS - 1));
    w_gap_done   = (r_cnt == 16'(GAP_CYCLES - 1));
    spi_clk      = 1'b0;
    spi_mosi     = 8'h00;
    shift_clk    = 1'b0;
    shift_ser    = 1'b0;
    shift_stcp   = 1'b0;
    shift_en     = 1'b1;
    case (r_state)
      S_SHIFT: begin
        shift_clk = r_cnt[0];
        shift_ser = ((16'(SR_BITS - 1) - (r_cnt >> 1)) == 16'(r_g));
        if (w_shift_done) w_next = S_LATCH;
      end
      S_LATCH: begin
        shift_stcp = 1'b1;
        w_next     = S_XFER;
      end
      S_XFER: begin
        shift_en = 1'b0;
        spi_clk  = (r_div >= 16'(SPI_DIV));
        spi_mosi = w_lane_bits;
        if (w_xfer_done) w_next = S_GAP;
      end
      default: begin
        if (w_gap_done) w_next = S_SHIFT;
      end
    endcase
  end

  always_ff @(posedge sys_clk_27MHz) begin
    if (rst) begin
      r_state    <= S_SHIFT;
      r_cnt      <= '0;
      r_div      <= '0;
      r_g        <= '0;
      r_f        <= '0;
      r_mode     <= 1'b0;
      r_pause    <= 1'b0;
      r_btn_meta <= 2'b00;
      r_btn_sync <= 2'b00;
    end else begin
      r_btn_meta <= btn;
      r_btn_sync <= r_btn_meta;
      r_state    <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
        r_div <= '0;
      end else if (r_state == S_XFER) begin
        if (w_div_last) begin
          r_div <= '0;
          r_cnt <= r_cnt + 16'd1;
        end else begin
          r_div <= r_div + 16'd1;
        end
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      // Buttons are frozen at group start so a group is never split between settings.
      if (r_state == S_LATCH) begin
        r_mode  <= r_btn_sync[0];
        r_pause <= r_btn_sync[1];
      end
      if (r_state == S_GAP && w_gap_done) begin
        if (r_g == GW'(SR_BITS - 1)) begin
          r_g <= '0;
          if (!r_pause) r_f <= r_f + 8'd1;
        end else begin
          r_g <= r_g + GW'(1);
        end
      end
    end
  end

  assign w_base   = 8'(r_cnt >> 3) + (8'(r_g) << 4) + r_f;
  assign w_bitsel = 3'd7 - r_cnt[2:0];

  for (genvar L = 0; L < 8; L++) begin : g_lane
    logic [7:0] w_byte;
    assign w_byte         = r_mode ? 8'(17 * (L + 1)) : (w_base + 8'(L));
    assign w_lane_bits[L] = w_byte[w_bitsel];
  end

  always_ff @(posedge sys_clk_27MHz) begin
    if (rst) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else begin
      r_hb_cnt <= r_hb_cnt + HB_BITS'(1);
      if (&r_hb_cnt) r_hb <= ~r_hb;
    end
  end

`ifdef HDMI_DETECT_EN
  localparam int WW = (DET_WINDOW > 1) ? $clog2(DET_WINDOW) : 1;
  logic [2:0]    r_tmds_s;
  logic [7:0]    r_edges;
  logic [WW-1:0] r_win;
  logic          r_present;

  always_ff @(posedge sys_clk_27MHz) begin
    if (rst) begin
      r_tmds_s  <= 3'b000;
      r_edges   <= 8'd0;
      r_win     <= '0;
      r_present <= 1'b0;
    end else begin
      r_tmds_s <= {r_tmds_s[1:0], I_tmds_clk_p};
      if (r_win == WW'(DET_WINDOW - 1)) begin
        r_win     <= '0;
        r_present <= (r_edges >= 8'(DET_MIN_EDGES));
        r_edges   <= 8'd0;
      end else begin
        r_win <= r_win + WW'(1);
        if (r_tmds_s[1] && !r_tmds_s[2] && r_edges != 8'hFF) r_edges <= r_edges + 8'd1;
      end
    end
  end

  assign w_hdmi_present = r_present;
  assign w_unused = ^{I_tmds_clk_n, I_tmds_data_p, I_tmds_data_n};
`else
  assign w_hdmi_present = 1'b0;
  assign w_unused = ^{I_tmds_clk_p, I_tmds_clk_n, I_tmds_data_p, I_tmds_data_n,
                      1'(DET_WINDOW), 1'(DET_MIN_EDGES)};
`endif

  assign led = {~r_f[2:0], ~(r_state == S_XFER), ~w_hdmi_present, ~r_hb};

endmodule

`default_nettype wire

// File: tb/tb_hdmi_to_matrix_top.sv
// Directed bench for hdmi_to_matrix_top: group select, SPI pattern, pause, reset, detector.
`default_nettype none

module tb_hdmi_to_matrix_top;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic       I_tmds_clk_p;
  logic       spi_clk;
  logic [7:0] spi_mosi;
  logic       shift_clk, shift_ser, shift_stcp, shift_en;
  logic [5:0] led;

  int vectors;
  int miscompares;

  logic [7:0] rx [8][48];
  logic       xfer_led2;
  logic       post_clk;

  hdmi_to_matrix_top #(.DET_WINDOW(1000)) dut (
    .sys_clk_27MHz(clk),
    .rst          (rst),
    .btn          (btn),
    .I_tmds_clk_p (I_tmds_clk_p),
    .I_tmds_clk_n (1'b0),
    .I_tmds_data_p(3'b000),
    .I_tmds_data_n(3'b000),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .shift_clk    (shift_clk),
    .shift_ser    (shift_ser),
    .shift_stcp   (shift_stcp),
    .shift_en     (shift_en),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  // Collects the 8 bits presented on shift_ser at each shift_clk rising phase.
  task automatic capture_shift(output logic [7:0] ser, output int n);
    int bits;
    logic p;
    ser = 8'h00; bits = 0; n = 0; p = 1'b0;
    while (bits < 8 && n < 40000) begin
      if (shift_clk === 1'b1 && p === 1'b0) begin
        ser = {ser[6:0], shift_ser};
        bits++;
      end
      p = shift_clk;
      if (bits < 8) begin
        tick();
        n++;
      end
    end
    if (bits < 8) timeout("shift_capture");
  endtask

  task automatic capture_xfer(output int len, output int edges);
    int n;
    int idx;
    logic p;
    n = 0;
    while (shift_en !== 1'b0 && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) timeout("xfer_start");
    len = 0; edges = 0; p = 1'b0;
    xfer_led2 = led[2];
    while (shift_en === 1'b0 && len < 4000) begin
      if (spi_clk === 1'b1 && p === 1'b0) begin
        idx = edges / 8;
        if (idx < 48)
          for (int l = 0; l < 8; l++) rx[l][idx] = {rx[l][idx][6:0], spi_mosi[l]};
        edges++;
      end
      p = spi_clk;
      len++;
      tick();
    end
    post_clk = spi_clk;
  endtask

  initial begin
    logic [7:0] ser;
    int n, len, edges;
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    btn = 2'b00;
    I_tmds_clk_p = 1'b0;

    for (int k = 0; k < 5; k++) tick();
    check("rst_spi_clk", 32'(spi_clk), 32'h0);
    check("rst_mosi", 32'(spi_mosi), 32'h00);
    check("rst_shift_clk", 32'(shift_clk), 32'h0);
    check("rst_shift_ser", 32'(shift_ser), 32'h0);
    check("rst_stcp", 32'(shift_stcp), 32'h0);
    check("rst_shift_en", 32'(shift_en), 32'h1);
    check("rst_led", 32'(led), 32'h3F);
    rst = 1'b0;

    // Frame 0, group 0
    capture_shift(ser, n);
    check("f0g0_ser", 32'(ser), 32'h01);
    check("f0g0_shift_len", 32'(n), 32'd15);
    tick();
    check("f0g0_stcp", 32'(shift_stcp), 32'h1);
    check("f0g0_stcp_shclk", 32'(shift_clk), 32'h0);
    capture_xfer(len, edges);
    check("f0g0_xfer_len", 32'(len), 32'd1536);
    check("f0g0_edges", 32'(edges), 32'd384);
    check("f0g0_led2", 32'(xfer_led2), 32'h0);
    check("f0g0_clk_end_low", 32'(post_clk), 32'h0);
    check("f0g0_gap_en", 32'(shift_en), 32'h1);
    check("f0g0_gap_led2", 32'(led[2]), 32'h1);
    check("f0g0_l3b0", 32'(rx[3][0]), 32'h03);
    check("f0g0_l3b1", 32'(rx[3][1]), 32'h04);
    check("f0g0_l3b2", 32'(rx[3][2]), 32'h05);
    check("f0g0_l0b47", 32'(rx[0][47]), 32'h2F);

    for (int g = 1; g < 8; g++) begin
      capture_shift(ser, n);
      capture_xfer(len, edges);
      if (g == 2) begin
        check("f0g2_ser", 32'(ser), 32'h04);
        check("f0g2_l0b0", 32'(rx[0][0]), 32'h20);
        check("f0g2_l7b10", 32'(rx[7][10]), 32'h31);
      end
      if (g == 7) begin
        check("f0g7_ser", 32'(ser), 32'h80);
        check("f0g7_l1b0", 32'(rx[1][0]), 32'h71);
      end
    end

    // Frame 1, group 0: frame counter advanced
    capture_shift(ser, n);
    check("f1_led_f", 32'(led[5:3]), 32'h6);
    check("f1g0_ser", 32'(ser), 32'h01);
    capture_xfer(len, edges);
    check("f1g0_l5b0", 32'(rx[5][0]), 32'h06);
    check("f1g0_l0b47", 32'(rx[0][47]), 32'h30);

    // Solid-colour mode on group 1
    btn = 2'b01;
    capture_shift(ser, n);
    capture_xfer(len, edges);
    check("m1_l0b0", 32'(rx[0][0]), 32'h11);
    check("m1_l0b47", 32'(rx[0][47]), 32'h11);
    check("m1_l7b0", 32'(rx[7][0]), 32'h88);
    check("m1_l3b5", 32'(rx[3][5]), 32'h44);

    // Pause across the frame end
    btn = 2'b10;
    for (int g = 2; g < 8; g++) begin
      capture_shift(ser, n);
      capture_xfer(len, edges);
    end
    capture_shift(ser, n);
    check("pause_led_f", 32'(led[5:3]), 32'h6);
    capture_xfer(len, edges);
    check("pause_l2b0", 32'(rx[2][0]), 32'h03);
    btn = 2'b00;

    // Reset in the middle of a transfer
    capture_shift(ser, n);
    n = 0;
    while (shift_en !== 1'b0 && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) timeout("xfer_before_reset");
    for (int k = 0; k < 100; k++) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_spi_clk", 32'(spi_clk), 32'h0);
    check("mid_rst_shift_en", 32'(shift_en), 32'h1);
    check("mid_rst_mosi", 32'(spi_mosi), 32'h00);
    check("mid_rst_led", 32'(led), 32'h3F);
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b0;
    capture_shift(ser, n);
    check("post_rst_ser", 32'(ser), 32'h01);
    check("post_rst_shift_len", 32'(n), 32'd15);
    capture_xfer(len, edges);
    check("post_rst_l3b0", 32'(rx[3][0]), 32'h03);
    check("post_rst_led_f", 32'(led[5:3]), 32'h7);

    // TMDS clock activity, then idle
    for (int k = 0; k < 2500; k++) begin
      if (k % 10 == 0) I_tmds_clk_p = ~I_tmds_clk_p;
      tick();
    end
`ifdef HDMI_DETECT_EN
    check("hdmi_active_led1", 32'(led[1]), 32'h0);
`else
    check("hdmi_active_led1", 32'(led[1]), 32'h1);
`endif
    for (int k = 0; k < 2500; k++) tick();
    check("hdmi_idle_led1", 32'(led[1]), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
